// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and width helper for the Wishbone matrix-multiply engine.
package matmul_pkg;

  localparam logic [11:0] CTRL_OFF = 12'h000;
  localparam logic [11:0] A_OFF    = 12'h100;
  localparam logic [11:0] B_OFF    = 12'h200;
  localparam logic [11:0] C_OFF    = 12'h300;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_IDLE_BIT  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate lane: DW x DW product accumulated at ACC_W bits.
// MATMUL_SIGNED_EN selects two's-complement operands instead of unsigned.
module matmul_mac #(
  parameter int DW    = 8,
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             last,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc;

  // Operand extension, product and running sum including the current term
  always_comb begin
`ifdef MATMUL_SIGNED_EN
    a_ext = ACC_W'(signed'(a));
    b_ext = ACC_W'(signed'(b));
`else
    a_ext = ACC_W'(a);
    b_ext = ACC_W'(b);
`endif
    // Low ACC_W bits of the product are exact in both modes
    prod = a_ext * b_ext;
    sum  = acc + prod;
  end

  // Accumulator: cleared on start and after each completed dot product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= {ACC_W{1'b0}};
    end else if (clear) begin
      acc <= {ACC_W{1'b0}};
    end else if (en) begin
      acc <= last ? {ACC_W{1'b0}} : sum;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/wb_matmul_engine.sv
// N x N matrix-multiply accelerator on a Wishbone slave: A/B load, CTRL handshake, C readback.
// Optional signed arithmetic with `define MATMUL_SIGNED_EN.
module wb_matmul_engine
  import matmul_pkg::*;
#(
  parameter int          N     = 4,
  parameter int          DW    = 8,
  parameter int          ACC_W = acc_width(DW, N),
  parameter logic [11:0] BASE  = 12'h340
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int NE = N * N;
  localparam int IW = $clog2(N);
  localparam int EW = $clog2(NE);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic [IW-1:0]   k;
  logic            ap_start;
  logic            ap_done;
  logic            ap_idle;

  logic [DW-1:0]    a_mem [NE];
  logic [DW-1:0]    b_mem [NE];
  logic [ACC_W-1:0] c_mem [NE];

  logic        valid;
  logic        req;
  logic        wr;
  logic        rd;
  logic        in_page;
  logic [3:0]  region;
  logic [5:0]  elem;
  logic        elem_ok;
  logic [EW-1:0] eidx;
  logic        hit_ctrl;
  logic        hit_a;
  logic        hit_b;
  logic        hit_c;
  logic        start;
  logic        busy;
  logic [31:0] ctrl_word;
  logic [31:0] rd_data;

  logic [EW-1:0]    a_idx;
  logic [EW-1:0]    b_idx;
  logic [EW-1:0]    c_idx;
  logic [DW-1:0]    op_a;
  logic [DW-1:0]    op_b;
  logic             mac_last;
  logic [ACC_W-1:0] mac_sum;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:DW]};

  // Bus decode: slave select, region/element lookup and start detection
  always_comb begin
    valid    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:20] == BASE);
    req      = valid & ~wbs_ack_o;
    wr       = req & wbs_we_i;
    rd       = req & ~wbs_we_i;
    busy     = (state == CALC);
    in_page  = (wbs_adr_i[19:12] == 8'h00);
    region   = wbs_adr_i[11:8];
    elem     = wbs_adr_i[7:2];
    elem_ok  = ({1'b0, elem} < 7'(NE));
    eidx     = elem[EW-1:0];
    hit_ctrl = in_page & (wbs_adr_i[11:2] == CTRL_OFF[11:2]);
    hit_a    = in_page & elem_ok & (region == A_OFF[11:8]);
    hit_b    = in_page & elem_ok & (region == B_OFF[11:8]);
    hit_c    = in_page & elem_ok & (region == C_OFF[11:8]);
    start    = wr & wbs_sel_i[0] & hit_ctrl & wbs_dat_i[CTRL_START_BIT] & ~busy;
  end

  // Read-data mux; C is extended to 32 bits according to the arithmetic mode
  always_comb begin
    ctrl_word                 = 32'h0000_0000;
    ctrl_word[CTRL_START_BIT] = ap_start;
    ctrl_word[CTRL_DONE_BIT]  = ap_done;
    ctrl_word[CTRL_IDLE_BIT]  = ap_idle;
    if (hit_ctrl) begin
      rd_data = ctrl_word;
    end else if (hit_a) begin
      rd_data = 32'(a_mem[eidx]);
    end else if (hit_b) begin
      rd_data = 32'(b_mem[eidx]);
    end else if (hit_c) begin
`ifdef MATMUL_SIGNED_EN
      rd_data = 32'(signed'(c_mem[eidx]));
`else
      rd_data = 32'(c_mem[eidx]);
`endif
    end else begin
      rd_data = 32'h0000_0000;
    end
  end

  // Operand addressing for the current (i, j, k) step
  always_comb begin
    a_idx    = EW'(i) * EW'(N) + EW'(k);
    b_idx    = EW'(k) * EW'(N) + EW'(j);
    c_idx    = EW'(i) * EW'(N) + EW'(j);
    op_a     = a_mem[a_idx];
    op_b     = b_mem[b_idx];
    mac_last = (k == LAST);
  end

  matmul_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (start),
    .en    (busy),
    .last  (mac_last),
    .a     (op_a),
    .b     (op_b),
    .sum   (mac_sum)
  );

  // Wishbone response, operand storage, counters and control FSM
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      i         <= {IW{1'b0}};
      j         <= {IW{1'b0}};
      k         <= {IW{1'b0}};
      ap_start  <= 1'b0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0000_0000;
      for (int n = 0; n < NE; n++) begin
        a_mem[n] <= {DW{1'b0}};
        b_mem[n] <= {DW{1'b0}};
        c_mem[n] <= {ACC_W{1'b0}};
      end
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rd_data : 32'h0000_0000;
      ap_start  <= start;
      // Clear-on-read; a done set later in this block takes priority
      if (rd & hit_ctrl) begin
        ap_done <= 1'b0;
      end
      if (wr & wbs_sel_i[0] & ~busy) begin
        if (hit_a) begin
          a_mem[eidx] <= wbs_dat_i[DW-1:0];
        end else if (hit_b) begin
          b_mem[eidx] <= wbs_dat_i[DW-1:0];
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            i       <= {IW{1'b0}};
            j       <= {IW{1'b0}};
            k       <= {IW{1'b0}};
            ap_idle <= 1'b0;
          end
        end
        CALC: begin
          if (mac_last) begin
            c_mem[c_idx] <= mac_sum;
            k            <= {IW{1'b0}};
            if (j == LAST) begin
              j <= {IW{1'b0}};
              if (i == LAST) begin
                i       <= {IW{1'b0}};
                state   <= IDLE;
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
              end else begin
                i <= i + IW'(1);
              end
            end else begin
              j <= j + IW'(1);
            end
          end else begin
            k <= k + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_matmul_engine.sv
// Directed self-checking bench for wb_matmul_engine (N=4, DW=8); honours MATMUL_SIGNED_EN.
module tb_wb_matmul_engine;

  localparam logic [31:0] BASE_ADR = 32'h3400_0000;
`ifdef MATMUL_SIGNED_EN
  localparam logic [31:0] SGN_EXP = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] SGN_EXP = 32'h0000_01FE;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] adr = 32'h0;
  logic        ack;
  logic [31:0] dat_o;

  int          cyc_n = 0;
  int          tests = 0;
  int          fails = 0;
  int          last_edge = 0;
  int          s_edge = 0;
  logic [31:0] rdata;
  logic        acked;

  wb_matmul_engine dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [11:0] aoff(input int r, input int c);
    return 12'h100 + 12'(4 * (r * 4 + c));
  endfunction
  function automatic logic [11:0] boff(input int r, input int c);
    return 12'h200 + 12'(4 * (r * 4 + c));
  endfunction
  function automatic logic [11:0] coff(input int r, input int c);
    return 12'h300 + 12'(4 * (r * 4 + c));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone transfer; at_edge > 0 places the ack-capturing clock edge at that edge number
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int at_edge);
    acked = 1'b0;
    rdata = 32'h0;
    @(negedge clk);
    while (at_edge > 0 && cyc_n < at_edge - 1) @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    for (int t = 0; t < 4 && !acked; t++) begin
      @(negedge clk);
      if (ack) begin
        acked = 1'b1;
        rdata = dat_o;
        last_edge = cyc_n;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    xfer(1'b1, BASE_ADR | 32'(off), d, 4'h1, 0);
    check("write_ack", 32'(acked), 32'h1);
  endtask

  task automatic rd(input string tag, input logic [11:0] off, input int at_edge, input logic [31:0] exp);
    xfer(1'b0, BASE_ADR | 32'(off), 32'h0, 4'hF, at_edge);
    check("read_ack", 32'(acked), 32'h1);
    check(tag, rdata, exp);
  endtask

  task automatic load_mats();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        wr(aoff(r, c), 32'(c));
        wr(boff(r, c), 32'(r * 4 + c + 1));
      end
    end
  endtask

  task automatic check_c_rows();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        rd("c_elem", coff(r, c), 0, 32'(62 + 6 * c));
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("idle_ack", 32'(ack), 32'h0);
    end
    check("reset_dat", dat_o, 32'h0);
    rd("reset_ctrl", 12'h000, 0, 32'h4);
    rd("reset_c21", coff(2, 1), 0, 32'h0);

    // Main multiply with exact latency: not done at S+63, done by S+65
    load_mats();
    wr(12'h000, 32'h1);
    s_edge = last_edge;
    rd("ctrl_s63", 12'h000, s_edge + 63, 32'h0);
    rd("ctrl_s65", 12'h000, s_edge + 65, 32'h6);
    rd("ctrl_cleared", 12'h000, 0, 32'h4);
    check_c_rows();

    // Busy protection; read on the done edge returns old value and done survives
    wr(12'h000, 32'h1);
    s_edge = last_edge;
    xfer(1'b1, BASE_ADR | 32'(aoff(0, 0)), 32'hFF, 4'h1, s_edge + 10);
    check("busy_wr_ack", 32'(acked), 32'h1);
    xfer(1'b1, BASE_ADR, 32'h1, 4'h1, s_edge + 12);
    check("busy_start_ack", 32'(acked), 32'h1);
    rd("ctrl_s64", 12'h000, s_edge + 64, 32'h0);
    rd("ctrl_s66", 12'h000, s_edge + 66, 32'h6);
    check_c_rows();
    rd("busy_a00", aoff(0, 0), 0, 32'h0);

    // Unmapped and address checks
    rd("unmapped_3fc", 12'h3FC, 0, 32'h0);
    rd("unmapped_ctrl4", 12'h004, 0, 32'h0);
    xfer(1'b0, 32'h3410_0000, 32'h0, 4'hF, 0);
    check("base341_noack", 32'(acked), 32'h0);
    xfer(1'b1, BASE_ADR | 32'(aoff(0, 1)), 32'h55, 4'h0, 0);
    check("sel0_ack", 32'(acked), 32'h1);
    rd("sel0_a01", aoff(0, 1), 0, 32'h1);
    wr(coff(0, 0), 32'h1234);
    rd("c_write_ignored", coff(0, 0), 0, 32'd62);

    // Signed / unsigned extension
    for (int n = 0; n < 16; n++) begin
      wr(aoff(n / 4, n % 4), 32'h0);
      wr(boff(n / 4, n % 4), 32'h0);
    end
    wr(aoff(0, 0), 32'hFF);
    wr(boff(0, 0), 32'h2);
    rd("a00_ff", aoff(0, 0), 0, 32'hFF);
    wr(12'h000, 32'h1);
    s_edge = last_edge;
    rd("sgn_done", 12'h000, s_edge + 66, 32'h6);
    rd("sgn_c00", coff(0, 0), 0, SGN_EXP);
    rd("sgn_c01", coff(0, 1), 0, 32'h0);

    // Reset during CALC, then a fresh run
    wr(12'h000, 32'h1);
    s_edge = last_edge;
    while (cyc_n < s_edge + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd("abort_ctrl", 12'h000, 0, 32'h4);
    for (int n = 0; n < 16; n++) begin
      rd("abort_c", coff(n / 4, n % 4), 0, 32'h0);
    end
    load_mats();
    wr(12'h000, 32'h1);
    s_edge = last_edge;
    rd("fresh_s63", 12'h000, s_edge + 63, 32'h0);
    rd("fresh_s65", 12'h000, s_edge + 65, 32'h6);
    check_c_rows();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_matmul_engine.md
# wb_matmul_engine

Parametrised N×N integer matrix-multiply accelerator on the Caravel user-project Wishbone slave bus. Firmware loads operand matrices A and B over Wishbone, starts the block through an ap_start/ap_done/ap_idle control register, and reads back result matrix C. It replaces the fixed 4×4, hard-coded-operand multiplier with loadable operands, a control handshake and a configurable size and width.

## Interface
- N, default 4: matrix dimension; legal values 2..8.
- DW, default 8: operand width in bits; legal values 4..16.
- ACC_W, default 2*DW+$clog2(N): accumulator and C element width; must be ≤ 32.
- BASE, default 12'h340: compared against wbs_adr_i[31:20] for slave select.

- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables; only bit 0 is used.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge; reset value 0.
- wbs_dat_o  out  32  read data; reset value 0.

## Operation
- Slave select: valid = stb & cyc & (adr[31:20]==BASE). Word offset is adr[11:2]; adr[19:12] must be 0, otherwise the access is an unmapped access.
- Address map (offsets within adr[11:0]):
  - 0x000 CTRL: bit0 ap_start (write 1 to start), bit1 ap_done (read-only, clear-on-read), bit2 ap_idle (read-only).
  - 0x100+4·(r·N+c): A[r][c], read/write.
  - 0x200+4·(r·N+c): B[r][c], read/write.
  - 0x300+4·(r·N+c): C[r][c], read-only.
- Writes to A, B or CTRL take effect only if wbs_sel_i[0]=1. A and B store wbs_dat_i[DW-1:0].
- Unmapped accesses, writes to C, and A/B writes while busy are acked and have no effect. Unmapped reads return 0.
- State machine:
  - IDLE → CALC on a CTRL write with dat[0]=1. Entry clears i, j, k and acc, and sets ap_idle=0.
  - In CALC, each cycle: acc += A[i][k]·B[k][j].
    - At k=N-1: write the final sum to C[i][j], clear acc, and advance j (and i on wrap).
    - After writing C[N-1][N-1]: go to IDLE, set ap_done=1, ap_idle=1.
- ap_start reads as 1 only in the single cycle in which the start is accepted. A start write while in CALC is ignored.
- Arithmetic is unsigned by default; see Configuration. Products and sums are computed at ACC_W bits, with no overflow possible for legal parameters.
- C reads return the value zero-extended to 32 bits.
- A, B, C and all control state reset to 0; ap_idle resets to 1. Reset during CALC aborts the computation and discards partial results.

## Timing
- Ack:
  - Registered, one wait state: wbs_ack_o=1 in the cycle after valid is first seen with wbs_ack_o=0.
  - Ack is a single-cycle pulse, and wbs_dat_o is valid in that same cycle.
  - Back-to-back transfers take 2 cycles each.
- Compute latency: exactly N³ cycles from the start-accepting clock edge to the edge that sets ap_done. That is 64 cycles for N=4.
- C[i][j] becomes readable on the cycle after its last MAC. Reading C during CALC returns whatever C currently holds, with no stall.
- Simultaneous CTRL read and ap_done set: the set wins, the read returns the old value, and ap_done stays 1.
- A CTRL read clears ap_done on the ack cycle.

## Configuration
- MATMUL_SIGNED_EN defined: A and B are two's-complement DW-bit values, products are sign-extended to ACC_W, and C reads are sign-extended to 32 bits.
- MATMUL_SIGNED_EN undefined: all values are unsigned and C reads are zero-extended.

## Structure
- Package matmul_pkg holds:
  - offset constants CTRL_OFF, A_OFF, B_OFF, C_OFF;
  - CTRL bit indices;
  - the FSM state typedef (IDLE, CALC);
  - the acc_width function.
- Sub-module matmul_mac is the natural split: a DW×DW multiply plus ACC_W accumulate with clear and signed-mode handling. The top level owns the Wishbone decode, storage, counters and FSM.

## Test plan
- Reset: after wb_rst_i pulses, CTRL reads 0x4, any C read returns 0, and wbs_ack_o stays 0 with no access.
- N=4, DW=8: load A rows {0,1,2,3} (all four rows) and B = 1..16 row-major, write CTRL=1. Poll until CTRL=0x6, which must happen exactly 64 cycles after the start edge. Every row of C must read {62, 68, 74, 80}. A second CTRL read returns 0x4.
- Busy protection: write CTRL=1, then at cycle 10 write A[0][0]=0xFF and CTRL=1 again. The results must equal the previous test's results, done must come at cycle 64, and A[0][0] still reads 0.
- Unmapped and address checks: a read at offset 0x3FC beyond C returns 0 with an ack. An access with adr[31:20]=0x341 gets no ack. A write with wbs_sel_i=0 leaves A unchanged.
- Signed mode: A[0][0]=0xFF, B[0][0]=2, everything else 0. C[0][0] reads 0xFFFFFFFE with MATMUL_SIGNED_EN and 0x000001FE without it.
- Reset at CALC cycle 20: CTRL reads 0x4 afterwards, all C elements read 0, and a fresh start completes normally.
